relu_layer_buffer_floating_point32: RTL and testbench
=====================================================

# relu_layer_buffer_floating_point32

Downstream stage of the 32-input pipelined FP32 adder in the DQN datapath. It takes the one-word-per-node sums the adder emits, applies ReLU, and collects NODES results into one of two ping-pong banks. It then replays each full bank as a back-to-back serial stream of NODES words, which is the format the next layer's 32-input adder consumes.

## Interface
- DATA_WIDTH, 32, word width (IEEE-754 single precision).
- NODES, 32, node results per layer vector (bank depth).
- ADDR_WIDTH, 5, log2(NODES).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-high reset (name kept per codebase; asserted = 1).
- i_valid  input  1  one node sum present on i_data this cycle.
- i_data  input  DATA_WIDTH  FP32 node sum from the adder.
- o_data  output  DATA_WIDTH  post-ReLU FP32 word of the draining vector.
- o_valid  output  1  o_data valid.
- o_last  output  1  marks element NODES-1 of a drained vector.
- o_overflow  output  1  sticky; an input was dropped because both banks were occupied.

## Operation
- ReLU is applied at write time:
  - i_data[31]=1 (any negative value, including -0, -Inf and negative NaN) stores 32'h0000_0000.
  - Otherwise i_data is stored unchanged; positive Inf and NaN pass through.
- Two banks, B0 and B1, each NODES x DATA_WIDTH, each with a state EMPTY, FILLING, FULL or DRAINING.
- Write side:
  - A write pointer wr_bank and a write address wr_addr (ADDR_WIDTH bits).
  - Each accepted i_valid writes bank[wr_bank][wr_addr] and increments wr_addr.
  - On the write at wr_addr=NODES-1, that bank becomes FULL, wr_addr wraps to 0 and wr_bank toggles.
- Accept rule: i_valid is accepted only if bank[wr_bank] is EMPTY or FILLING. Otherwise the word is dropped, o_overflow is set, and wr_addr and wr_bank hold.
- Read side:
  - Read pointers rd_bank and rd_addr.
  - When bank[rd_bank] is FULL and no drain is active, that bank becomes DRAINING.
  - While draining, one word is output per cycle with no stall. Downstream has no backpressure.
  - After element NODES-1, the bank returns to EMPTY and rd_bank toggles.
- If the other bank is already FULL when a drain ends, its drain starts on the very next cycle, so the two vectors stream back to back with no gap.
- A bank can be written in the same cycle its drain completes. EMPTY takes effect at that edge, so the earliest write to that bank is on the following edge.

## Timing
- Reset values: o_data=0, o_valid=0, o_last=0, o_overflow=0. Both banks EMPTY, all pointers 0. Bank contents are don't-care.
- Reset asserted mid-fill or mid-drain immediately clears all outputs and state. A partial vector is discarded.
- Latency, with edge E being the edge that writes element NODES-1:
  - Drain state is set at E+1.
  - Element 0 appears on o_data/o_valid registered at E+2.
  - Element k appears at E+2+k.
  - o_last is high at E+1+NODES.
- o_valid stays high for exactly NODES consecutive cycles per vector, or 2*NODES for back-to-back vectors.
- o_last is high only together with o_valid.
- Simultaneous write and read on different banks are independent.
- Write to the bank that is currently draining is impossible by the accept rule.
- o_overflow stays high until reset.

## Structure
- Shared package: DATA_WIDTH, FP32_ZERO (32'h0), FP32 sign-bit index (31), and the bank-state encoding (EMPTY/FILLING/FULL/DRAINING, 2 bits).
- Sub-module relu_floating_point32: combinational, DATA_WIDTH in and out, sign-bit test.
- Top level holds the two bank RAM arrays, the per-bank state registers, the write/read pointer logic and the output registers.

## Test plan
- Single vector:
  - Stimulus: 32 sums alternating 32'h3F80_0000 (1.0) and 32'hBF80_0000 (-1.0), one every 40 cycles.
  - Required: 32 consecutive o_valid words alternating 3F80_0000 and 0000_0000; o_last on the 32nd; first output 2 cycles after the last write.
- Special values:
  - Stimulus: inputs 8000_0000, 7F80_0000, FF80_0000, 7FC0_0000, FFC0_0000.
  - Required outputs: 0000_0000, 7F80_0000, 0000_0000, 7FC0_0000, 0000_0000.
- Ping-pong:
  - Stimulus: 64 sums on consecutive cycles.
  - Required: 64 consecutive o_valid cycles with no gap; o_last high at outputs 32 and 64; o_overflow=0.
- Overflow:
  - Stimulus: 96 sums on consecutive cycles.
  - Required: the word arriving while both banks are full is dropped and o_overflow rises on that edge and stays 1. Output is the first 64 values, then resumes correctly once a bank empties.
- Reset mid-drain:
  - Stimulus: assert rst_n=1 at drain element 10.
  - Required: o_valid=0 asynchronously. After release, a fresh 32-word vector drains from element 0 with correct values.

Source files
------------

// File: rtl/relu_layer_buffer_floating_point32_pkg.sv
// Shared constants and bank-state encoding for the ReLU layer buffer.
// FP32 words, 32 nodes per layer vector.
package relu_layer_buffer_floating_point32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NODES      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int SIGN_BIT   = 31;

  localparam logic [DATA_WIDTH-1:0] FP32_ZERO = '0;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/relu_layer_buffer_floating_point32_relu.sv
// FP32 ReLU: any word with the sign bit set (incl. -0, -Inf, -NaN) maps to +0.
// Positive values, +Inf and positive NaN pass unchanged.
module relu_floating_point32
  import relu_layer_buffer_floating_point32_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  assign y = x[SIGN_BIT] ? FP32_ZERO : x;

endmodule

// File: rtl/relu_layer_buffer_floating_point32.sv
// Ping-pong buffer: ReLU at write time, two NODES-deep banks,
// each full bank replayed as a gapless serial stream.
module relu_layer_buffer_floating_point32
  import relu_layer_buffer_floating_point32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NODES - 1);

  logic [DATA_WIDTH-1:0] mem0 [NODES];
  logic [DATA_WIDTH-1:0] mem1 [NODES];

  bank_state_e bank_st [2];
  bank_state_e st_nxt  [2];

  logic                  wr_bank;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] relu_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_ok;
  logic                  wr_last;
  logic                  drain_on;
  logic                  rd_last;

  relu_floating_point32 u_relu (
    .x (i_data),
    .y (relu_word)
  );

  assign wr_ok    = i_valid &&
                    (bank_st[wr_bank] == ST_EMPTY ||
                     bank_st[wr_bank] == ST_FILLING);
  assign wr_last  = wr_addr == LAST_ADDR;
  assign drain_on = bank_st[rd_bank] == ST_DRAINING;
  assign rd_last  = rd_addr == LAST_ADDR;
  assign rd_word  = rd_bank ? mem1[rd_addr] : mem0[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_bank) mem1[wr_addr] <= relu_word;
      else         mem0[wr_addr] <= relu_word;
    end
  end

  // Write and read only ever touch a bank in disjoint states, so no priority clash.
  always_comb begin
    st_nxt[0] = bank_st[0];
    st_nxt[1] = bank_st[1];
    if (wr_ok)
      st_nxt[wr_bank] = wr_last ? ST_FULL : ST_FILLING;
    if (drain_on && rd_last) begin
      st_nxt[rd_bank] = ST_EMPTY;
      if (bank_st[~rd_bank] == ST_FULL)
        st_nxt[~rd_bank] = ST_DRAINING;
    end else if (!drain_on && bank_st[rd_bank] == ST_FULL) begin
      st_nxt[rd_bank] = ST_DRAINING;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bank_st[0] <= ST_EMPTY;
      bank_st[1] <= ST_EMPTY;
    end else begin
      bank_st[0] <= st_nxt[0];
      bank_st[1] <= st_nxt[1];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_addr    <= '0;
      wr_bank    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (wr_ok) begin
      wr_addr <= wr_addr + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
    end else if (i_valid) begin
      o_overflow <= 1'b1;
    end
  end

  // rd_addr wraps to 0 on the last element, so a queued bank starts at element 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_addr <= '0;
      rd_bank <= 1'b0;
      o_data  <= FP32_ZERO;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      o_valid <= drain_on;
      o_last  <= drain_on && rd_last;
      if (drain_on) begin
        o_data  <= rd_word;
        rd_addr <= rd_addr + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_relu_layer_buffer_floating_point32.sv
// Scoreboard bench for the ReLU ping-pong layer buffer.
// Stimulus pushes hand-computed expectations; a monitor pops on o_valid.
module tb_relu_layer_buffer_floating_point32;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_overflow;

  exp_t exp_q[$];
  int   runs[$];
  int   run;
  int   out_cnt;
  int   acc_cnt;
  int   checks;
  int   errors;

  relu_layer_buffer_floating_point32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every presented word against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      run = 0;
    end else begin
      checks++;
      if (o_last && !o_valid) begin
        errors++;
        $display("FAIL last_wo_valid o_last=1 o_valid=0 required o_last=0");
      end
      if (o_valid) begin
        exp_t e;
        out_cnt++;
        run++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h, required no output", o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e.d || o_last !== e.last) begin
            errors++;
            $display("FAIL out_word got %h last %b, required %h last %b",
                     o_data, o_last, e.d, e.last);
          end
        end
      end else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] e,
                      input bit accepted);
    exp_t x;
    i_valid = 1'b1;
    i_data  = d;
    if (accepted) begin
      x.d    = e;
      x.last = (acc_cnt % 32) == 31;
      exp_q.push_back(x);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input string name, input int n);
    checks++;
    if (runs.size() == 0) begin
      errors++;
      $display("FAIL %s run missing, required length %0d", name, n);
    end else begin
      int r;
      r = runs.pop_front();
      if (r != n) begin
        errors++;
        $display("FAIL %s run length %0d required %0d", name, r, n);
      end
    end
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (out_cnt < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (out_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_out timeout count %0d required %0d", out_cnt, target);
    end
  endtask

  initial begin
    logic [31:0] w;
    checks  = 0;
    errors  = 0;
    out_cnt = 0;
    acc_cnt = 0;
    run     = 0;
    i_valid = 1'b0;
    i_data  = '0;
    rst_n   = 1'b1;
    #1;
    chk("rst_o_data", o_data, 32'h0);
    chk("rst_o_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_o_last", {31'b0, o_last}, 32'h0);
    chk("rst_o_ovf", {31'b0, o_overflow}, 32'h0);
    idle(3);
    rst_n = 1'b0;
    idle(2);

    // Single vector, one sum every 40 cycles, alternating +1.0 / -1.0.
    runs.delete();
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) send(32'h3F80_0000, 32'h3F80_0000, 1'b1);
      else            send(32'hBF80_0000, 32'h0000_0000, 1'b1);
      if (i < 31) idle(39);
    end
    idle(1);
    chk("lat_e1_valid", {31'b0, o_valid}, 32'h0);
    idle(1);
    chk("lat_e2_valid", {31'b0, o_valid}, 32'h1);
    chk("lat_e2_data", o_data, 32'h3F80_0000);
    idle(40);
    expect_run("single", 32);

    // Special values followed by positive filler.
    runs.delete();
    send(32'h8000_0000, 32'h0000_0000, 1'b1);
    send(32'h7F80_0000, 32'h7F80_0000, 1'b1);
    send(32'hFF80_0000, 32'h0000_0000, 1'b1);
    send(32'h7FC0_0000, 32'h7FC0_0000, 1'b1);
    send(32'hFFC0_0000, 32'h0000_0000, 1'b1);
    for (int i = 5; i < 32; i++) begin
      w = 32'h4000_0000 | i;
      send(w, w, 1'b1);
    end
    idle(40);
    expect_run("special", 32);

    // Ping-pong: 64 back-to-back sums, mixed sign.
    runs.delete();
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 1) begin
        w = 32'hC000_0000 | i;
        send(w, 32'h0, 1'b1);
      end else begin
        w = 32'h3F80_0000 | i;
        send(w, w, 1'b1);
      end
    end
    idle(80);
    expect_run("pingpong", 64);
    chk("pp_ovf", {31'b0, o_overflow}, 32'h0);

    // Overflow: word 64 arrives while bank 0 is still draining.
    runs.delete();
    for (int i = 0; i < 96; i++) begin
      w = 32'h4200_0000 | i;
      if (i == 64) chk("ovf_before", {31'b0, o_overflow}, 32'h0);
      send(w, w, i != 64);
      if (i == 64) chk("ovf_rise", {31'b0, o_overflow}, 32'h1);
    end
    send(32'h4300_0000, 32'h4300_0000, 1'b1);
    idle(80);
    expect_run("ovf_first", 64);
    expect_run("ovf_resume", 32);
    chk("ovf_sticky", {31'b0, o_overflow}, 32'h1);

    // Reset during drain element 10.
    for (int i = 0; i < 32; i++) begin
      w = 32'h3F00_0000 | (i << 4);
      send(w, w, 1'b1);
    end
    wait_out(out_cnt + 10);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", {31'b0, o_valid}, 32'h1);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, o_valid}, 32'h0);
    chk("mid_rst_last", {31'b0, o_last}, 32'h0);
    chk("mid_rst_ovf", {31'b0, o_overflow}, 32'h0);
    chk("mid_rst_data", o_data, 32'h0);
    exp_q.delete();
    acc_cnt = 0;
    idle(2);
    rst_n = 1'b0;
    runs.delete();
    idle(1);
    for (int i = 0; i < 32; i++) begin
      w = (i == 7) ? 32'hC100_0000 : (32'h4100_0000 | i);
      send(w, (i == 7) ? 32'h0 : w, 1'b1);
    end
    idle(40);
    expect_run("post_rst", 32);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_words %0d left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
